// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor table, FSM state encoding and the even-parity rule
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DIV_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // clk cycles per oversample tick for each baud_select code
    function automatic logic [UART_DIV_W-1:0] div_lookup(input logic [2:0] sel);
        logic [UART_DIV_W-1:0] div;
        case (sel)
            3'd0:    div = 13'd5208;
            3'd1:    div = 13'd1302;
            3'd2:    div = 13'd326;
            3'd3:    div = 13'd163;
            3'd4:    div = 13'd81;
            3'd5:    div = 13'd41;
            3'd6:    div = 13'd27;
            default: div = 13'd14;
        endcase
        return div;
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Free-running baud divisor: counts 0..div-1 and pulses tick on the last count.
// restart forces the count back to zero so a new frame starts on a clean bit boundary.
module uart_tx_baud_gen #(
    parameter int DIV_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = (count == (div - DIV_W'(1)));

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 11-bit frames (start, 8 data LSB first, even parity, stop) on TxD.
// Optional 1-byte holding register enabled by defining UART_TX_HOLD_REG_EN.
module uart_transmitter #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       TX_EN,
    input  logic [7:0] Tx_DATA,
    input  logic       Tx_WR,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);

    import uart_pkg::*;

    localparam int                TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    uart_state_t      state;
    uart_state_t      next_state;
    logic [7:0]       shreg;
    logic             parity_bit;
    logic [2:0]       bit_idx;
    logic [TICK_W-1:0] tick_cnt;
    logic [DIV_W-1:0] div_q;

    logic             tick;
    logic             bit_end;
    logic             frame_active;
    logic             accept;
    logic             handoff;
    logic             load_frame;
    logic [7:0]       load_data;
    logic [DIV_W-1:0] load_div;

    assign frame_active = (state != ST_IDLE);
    assign bit_end      = tick && (tick_cnt == TICK_LAST);
    assign accept       = Tx_WR && TX_EN && !Tx_BUSY && (state == ST_IDLE);

`ifdef UART_TX_HOLD_REG_EN
    logic [7:0]       hold_data;
    logic [DIV_W-1:0] hold_div;
    logic             hold_full;
    logic             hold_load;

    assign hold_load = frame_active && !hold_full && Tx_WR && TX_EN;
    // A write landing on the Tx_DONE cycle bypasses the hold register and starts directly
    assign handoff   = (state == ST_STOP) && bit_end && (hold_full || hold_load);
    assign load_data = hold_full ? hold_data : Tx_DATA;
    assign load_div  = hold_full ? hold_div : DIV_W'(div_lookup(baud_select));
    assign Tx_BUSY   = frame_active && hold_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_div  <= '0;
        end else if (handoff) begin
            hold_full <= 1'b0;
        end else if (hold_load) begin
            hold_full <= 1'b1;
            hold_data <= Tx_DATA;
            hold_div  <= DIV_W'(div_lookup(baud_select));
        end
    end
`else
    assign handoff   = 1'b0;
    assign load_data = Tx_DATA;
    assign load_div  = DIV_W'(div_lookup(baud_select));
    assign Tx_BUSY   = frame_active;
`endif

    assign load_frame = accept || handoff;

    uart_tx_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (load_frame),
        .div     (div_q),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept)                     next_state = ST_START;
            ST_START:  if (bit_end)                    next_state = ST_DATA;
            ST_DATA:   if (bit_end && bit_idx == 3'd7) next_state = ST_PARITY;
            ST_PARITY: if (bit_end)                    next_state = ST_STOP;
            ST_STOP:   if (bit_end)                    next_state = handoff ? ST_START : ST_IDLE;
            default:                                   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        TxD     = 1'b1;
        Tx_DONE = 1'b0;
        case (state)
            ST_START:  TxD     = 1'b0;
            ST_DATA:   TxD     = shreg[0];
            ST_PARITY: TxD     = parity_bit;
            ST_STOP:   Tx_DONE = bit_end;
            default:   TxD     = 1'b1;
        endcase
    end

    // Frame datapath: byte, parity and divisor are frozen at load so later input changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_idx    <= '0;
            tick_cnt   <= '0;
            div_q      <= '0;
        end else if (load_frame) begin
            shreg      <= load_data;
            parity_bit <= even_parity(load_data);
            bit_idx    <= '0;
            tick_cnt   <= '0;
            div_q      <= load_div;
        end else if (frame_active && tick) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
            if (bit_end && state == ST_DATA) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus predicts frames from timing arithmetic,
// a monitor decodes TxD and compares. Honours UART_TX_HOLD_REG_EN when defined.
module tb_uart_transmitter;

    typedef struct {
        logic [7:0] data;
        int         bt;
        longint     start;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       TX_EN;
    logic [7:0] Tx_DATA;
    logic       Tx_WR;
    logic       TxD;
    logic       Tx_BUSY;
    logic       Tx_DONE;

    longint cyc = 0;
    int     passed = 0;
    int     total = 0;
    exp_t   sb[$];
    bit     mon_busy = 1'b0;
    longint last_start = -1;
    longint last_end = -1;
    int     div_tab[8] = '{5208, 1302, 326, 163, 81, 41, 27, 14};

    uart_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .TX_EN       (TX_EN),
        .Tx_DATA     (Tx_DATA),
        .Tx_WR       (Tx_WR),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY),
        .Tx_DONE     (Tx_DONE)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: a write accepted on idle starts the next clk; with a holding register a
    // write during a frame (hold empty) starts right after the last scheduled frame ends.
    task automatic do_write(input logic [7:0] d, input logic [2:0] sel);
        longint w;
        longint st;
        bit     take;
        int     bt;
        @(negedge clk);
        w = cyc;
        Tx_DATA = d;
        baud_select = sel;
        Tx_WR = 1'b1;
        bt = div_tab[sel] * 16;
        take = 1'b0;
        st = 0;
        if (TX_EN) begin
            if (w > last_end) begin
                take = 1'b1;
                st = w + 1;
            end else begin
`ifdef UART_TX_HOLD_REG_EN
                if (last_start <= w) begin
                    take = 1'b1;
                    st = last_end + 1;
                end
`endif
            end
        end
        if (take) begin
            sb.push_back('{data: d, bt: bt, start: st});
            last_start = st;
            last_end = st + 11 * bt - 1;
        end
        @(negedge clk);
        Tx_WR = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || mon_busy || cyc <= last_end) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_reached"}, (n < 40000), 1);
        @(negedge clk);
        check({name, "_busy_low"}, Tx_BUSY, 0);
        check({name, "_txd_idle"}, TxD, 1);
    endtask

    // Monitor: decodes each frame on TxD and compares against the scoreboard head
    initial begin
        exp_t        e;
        logic [10:0] fb;
        int          bad;
        int          done_cnt;
        longint      done_at;
        bit          abort;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || TxD !== 1'b0) continue;
            if (sb.size() == 0) begin
                check("unexpected_frame_start", cyc, -1);
                continue;
            end
            e = sb.pop_front();
            mon_busy = 1'b1;
            check("start_cycle", cyc, e.start);
            fb = {1'b1, ^e.data, e.data, 1'b0};
            done_cnt = 0;
            done_at = -1;
            abort = 1'b0;
            for (int k = 0; k < 11 && !abort; k++) begin
                bad = 0;
                for (int t = 0; t < e.bt; t++) begin
                    if (k != 0 || t != 0) @(negedge clk);
                    if (reset === 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    if (TxD !== fb[k]) bad++;
`ifndef UART_TX_HOLD_REG_EN
                    if (Tx_BUSY !== 1'b1) bad++;
`endif
                    if (Tx_DONE === 1'b1) begin
                        done_cnt++;
                        done_at = cyc;
                    end
                end
                if (!abort) check($sformatf("byte%02h_bit%0d_bad_cycles", e.data, k), bad, 0);
            end
            if (!abort) begin
                check($sformatf("byte%02h_done_count", e.data), done_cnt, 1);
                check($sformatf("byte%02h_done_cycle", e.data), done_at, e.start + 11 * e.bt - 1);
            end
            mon_busy = 1'b0;
        end
    end

    initial begin
        longint target;
        int     gap;
        logic [2:0] sel;
        reset = 1'b1;
        Tx_WR = 1'b1;
        TX_EN = 1'b1;
        Tx_DATA = 8'h55;
        baud_select = 3'd7;

        // Held reset with a write strobe: line stays idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_txd", TxD, 1);
            check("rst_busy", Tx_BUSY, 0);
            check("rst_done", Tx_DONE, 0);
        end
        reset = 1'b0;
        Tx_WR = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_txd", TxD, 1);

        do_write(8'hA5, 3'd7);
        wait_idle("a5");
        do_write(8'h07, 3'd7);
        wait_idle("p07");

        do_write(8'h3C, 3'd7);
        repeat (500) @(negedge clk);
        do_write(8'hFF, 3'd7);
        wait_idle("midwrite");

        // Reset during data bit 4
        do_write(8'hC3, 3'd7);
        target = last_start + 5 * div_tab[7] * 16 + 100;
        while (cyc < target) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        last_start = -1;
        last_end = -1;
        @(negedge clk);
        check("midrst_txd", TxD, 1);
        check("midrst_busy", Tx_BUSY, 0);
        check("midrst_done", Tx_DONE, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        do_write(8'h5A, 3'd7);
        wait_idle("after_rst");

        // baud_select and TX_EN change mid-frame
        do_write(8'h96, 3'd7);
        repeat (300) @(negedge clk);
        baud_select = 3'd0;
        TX_EN = 1'b0;
        wait_idle("en_drop");
        do_write(8'h11, 3'd7);
        repeat (300) @(negedge clk);
        check("en_off_busy", Tx_BUSY, 0);
        check("en_off_txd", TxD, 1);
        TX_EN = 1'b1;

        for (int i = 0; i < 5; i++) begin
            sel = 3'($urandom_range(6, 7));
            TX_EN = ($urandom_range(0, 4) != 0);
            do_write(8'($urandom), sel);
            TX_EN = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                gap = $urandom_range(0, 11 * div_tab[sel] * 16);
                repeat (gap) @(negedge clk);
                do_write(8'($urandom), 3'($urandom_range(6, 7)));
            end
            wait_idle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
